// File: rtl/ggt_batch_sequencer.sv
// Walks N_PAIRS operand pairs from a ROM through ggt_top and writes each result to a RAM slot at the same index.
// A watchdog replaces a missing result with all ones so a hung core cannot stall the batch.
module ggt_batch_sequencer #(
  parameter int N_PAIRS = 16,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                run_i,
  output logic [ADDR_W-1:0]   rom_addr_o,
  input  logic [2*DATA_W-1:0] rom_data_i,
  output logic                ggt_start_o,
  output logic [DATA_W-1:0]   ggt_zahl1_o,
  output logic [DATA_W-1:0]   ggt_zahl2_o,
  input  logic                ggt_valid_i,
  input  logic [DATA_W-1:0]   ggt_ergebnis_i,
  output logic [ADDR_W-1:0]   res_addr_o,
  output logic [DATA_W-1:0]   res_data_o,
  output logic                res_wren_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [ADDR_W:0]     pairs_done_o,
  output logic [ADDR_W:0]     err_cnt_o
);

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  SAT      = CNT_W'(N_PAIRS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PAIRS - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DATA_W-1:0] zahl1_q, zahl1_d, zahl2_q, zahl2_d, res_q, res_d;
  logic [CNT_W-1:0]  pairs_q, pairs_d, err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      zahl1_q <= '0;
      zahl2_q <= '0;
      res_q   <= '0;
      pairs_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_i;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      zahl1_q <= zahl1_d;
      zahl2_q <= zahl2_d;
      res_q   <= res_d;
      pairs_q <= pairs_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    zahl1_d = zahl1_q;
    zahl2_d = zahl2_q;
    res_d   = res_q;
    pairs_d = pairs_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (run_i && !run_q) begin
          state_d = S_FETCH;
          idx_d   = '0;
          pairs_d = '0;
          err_d   = '0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        zahl1_d = rom_data_i[2*DATA_W-1:DATA_W];
        zahl2_d = rom_data_i[DATA_W-1:0];
        if (rom_data_i == '0) begin
          res_d   = '0;
          state_d = S_WRITE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        // wd_q==0 marks the first WAIT cycle, where valid may still be the previous result
        if (wd_q != '0 && ggt_valid_i) begin
          res_d   = ggt_ergebnis_i;
          state_d = S_WRITE;
        end else if (wd_q == WD_LAST) begin
          res_d   = '1;
          err_d   = (err_q < SAT) ? err_q + 1'b1 : err_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        pairs_d = (pairs_q < SAT) ? pairs_q + 1'b1 : pairs_q;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (!run_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr_o   = idx_q;
  assign ggt_start_o  = (state_q == S_ISSUE);
  assign ggt_zahl1_o  = zahl1_q;
  assign ggt_zahl2_o  = zahl2_q;
  assign res_addr_o   = idx_q;
  assign res_data_o   = res_q;
  assign res_wren_o   = (state_q == S_WRITE);
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = (state_q == S_DONE);
  assign pairs_done_o = pairs_q;
  assign err_cnt_o    = err_q;

endmodule

// File: tb/tb_ggt_batch_sequencer.sv
// Directed bench: a 4-pair sequencer (TIMEOUT=20) and a 1-pair sequencer share one behavioural GCD core model.
// Expected RAM writes are queued when a batch is launched and checked as res_wren_o pulses appear.
module tb_ggt_batch_sequencer;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic        run0, start0, wren0, busy0, done0;
  logic [7:0]  rom_addr0, raddr0;
  logic [31:0] rom_data0;
  logic [15:0] z1_0, z2_0, rdata0;
  logic [8:0]  pairs0, err0;
  // single-pair instance
  logic        run1, start1, wren1, busy1, done1;
  logic [7:0]  rom_addr1, raddr1;
  logic [31:0] rom_data1;
  logic [15:0] z1_1, z2_1, rdata1;
  logic [8:0]  pairs1, err1;
  // shared core model outputs
  logic        g_valid;
  logic [15:0] g_res;

  ggt_batch_sequencer #(.N_PAIRS(4), .ADDR_W(8), .DATA_W(16), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_i(rst), .run_i(run0), .rom_addr_o(rom_addr0), .rom_data_i(rom_data0),
    .ggt_start_o(start0), .ggt_zahl1_o(z1_0), .ggt_zahl2_o(z2_0), .ggt_valid_i(g_valid),
    .ggt_ergebnis_i(g_res), .res_addr_o(raddr0), .res_data_o(rdata0), .res_wren_o(wren0),
    .busy_o(busy0), .done_o(done0), .pairs_done_o(pairs0), .err_cnt_o(err0));

  ggt_batch_sequencer #(.N_PAIRS(1)) u_dut1 (
    .clk(clk), .rst_i(rst), .run_i(run1), .rom_addr_o(rom_addr1), .rom_data_i(rom_data1),
    .ggt_start_o(start1), .ggt_zahl1_o(z1_1), .ggt_zahl2_o(z2_1), .ggt_valid_i(g_valid),
    .ggt_ergebnis_i(g_res), .res_addr_o(raddr1), .res_data_o(rdata1), .res_wren_o(wren1),
    .busy_o(busy1), .done_o(done1), .pairs_done_o(pairs1), .err_cnt_o(err1));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gcd(input logic [15:0] a_in, input logic [15:0] b_in);
    logic [15:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  // ROM models: one-cycle read latency
  logic [31:0] rom0 [4];
  always @(posedge clk) rom_data0 <= rom0[rom_addr0[1:0]];
  always @(posedge clk) rom_data1 <= (rom_addr1 == 8'd0) ? {16'd24255, 16'd12540} : 32'd0;

  // Behavioural core: valid is a level that stays up until the next start (or one cycle past it when stale_hold)
  int          lat_cfg;
  logic        stale_hold, hang_en;
  logic [15:0] hang_val, ma, mb, sel_z1, sel_z2;
  int          mcnt;
  logic        mdrop;
  assign sel_z1 = start1 ? z1_1 : z1_0;
  assign sel_z2 = start1 ? z2_1 : z2_0;
  always @(posedge clk) begin
    if (rst) begin
      g_valid <= 1'b0;
      g_res   <= '0;
      mcnt    <= 0;
      mdrop   <= 1'b0;
    end else if (start0 || start1) begin
      ma    <= sel_z1;
      mb    <= sel_z2;
      mcnt  <= (hang_en && start0 && sel_z1 == hang_val) ? 0 : lat_cfg;
      mdrop <= stale_hold;
      if (!stale_hold) g_valid <= 1'b0;
    end else begin
      if (mdrop) begin
        g_valid <= 1'b0;
        mdrop   <= 1'b0;
      end
      if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          g_valid <= 1'b1;
          g_res   <= gcd(ma, mb);
        end
      end
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] z1;
    logic [15:0] z2;
    int          lat;
  } exp_t;
  exp_t sbq[$];
  exp_t e_mon;

  task automatic load_batch(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3);
    logic [31:0] p [4];
    exp_t e;
    p[0] = a0; p[1] = a1; p[2] = a2; p[3] = a3;
    for (int i = 0; i < 4; i++) begin
      rom0[i] = p[i];
      e.addr = 8'(i);
      e.z1   = p[i][31:16];
      e.z2   = p[i][15:0];
      if (p[i] == 32'd0) begin
        e.data = 16'd0;
        e.lat  = 0;
      end else if (hang_en && e.z1 == hang_val) begin
        e.data = 16'hFFFF;
        e.lat  = TO + 1;
      end else begin
        e.data = gcd(e.z1, e.z2);
        e.lat  = lat_cfg + 2;
      end
      sbq.push_back(e);
    end
  endtask

  // Output monitor and scoreboard
  int   n_starts = 0;
  int   start_cyc = 0;
  int   n_wren1 = 0;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (start0) begin
      n_starts  <= n_starts + 1;
      start_cyc <= cyc;
      check("start_width", start_prev, 1'b0);
      if (sbq.size() > 0) begin
        check("issue_z1", z1_0, sbq[0].z1);
        check("issue_z2", z2_0, sbq[0].z2);
      end
    end
    start_prev <= start0;
    if (wren0) begin
      check("sb_nonempty", sbq.size() > 0, 1'b1);
      if (sbq.size() > 0) begin
        e_mon = sbq.pop_front();
        check("wr_addr", raddr0, e_mon.addr);
        check("wr_data", rdata0, e_mon.data);
        check("hold_z1", z1_0, e_mon.z1);
        check("hold_z2", z2_0, e_mon.z2);
        if (e_mon.lat != 0) check("latency", cyc - start_cyc, e_mon.lat);
      end
    end
    if (wren1) begin
      n_wren1 <= n_wren1 + 1;
      check("single_addr", raddr1, 8'd0);
      check("single_data", rdata1, 16'd165);
    end
  end

  task automatic wait_done(input bit which, input int budget);
    int k;
    k = 0;
    while (!(which ? done1 : done0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(which ? "done1_reached" : "done0_reached", which ? done1 : done0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {rom_addr0, start0, z1_0, z2_0, raddr0}, 64'd0);
    check({tag, "_b"}, {rdata0, wren0, busy0, done0, pairs0, err0}, 64'd0);
  endtask

  int seen;
  int base;

  initial begin
    rst = 1'b1; run0 = 1'b0; run1 = 1'b0;
    lat_cfg = 4; stale_hold = 1'b0; hang_en = 1'b0; hang_val = 16'd0;
    for (int i = 0; i < 4; i++) rom0[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_single", {busy1, done1, pairs1, err1, wren1}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // single pair on the N_PAIRS=1 instance
    run1 = 1'b1;
    wait_done(1'b1, 200);
    check("single_pairs", pairs1, 9'd1);
    check("single_err", err1, 9'd0);
    check("single_wren_cnt", n_wren1, 1);
    run1 = 1'b0;
    @(negedge clk);

    // mixed batch with a skipped (0,0) pair
    load_batch({16'd48, 16'd18}, {16'd17, 16'd5}, 32'd0, {16'd1000, 16'd250});
    base = n_starts;
    run0 = 1'b1;
    wait_done(1'b0, 500);
    check("b_sb_empty", sbq.size(), 0);
    check("b_starts", n_starts - base, 3);
    check("b_pairs", pairs0, 9'd4);
    check("b_err", err0, 9'd0);
    check("b_busy_done", busy0, 1'b0);
    run0 = 1'b0;
    @(negedge clk);
    check("b_idle_done", done0, 1'b0);
    check("b_idle_pairs_kept", pairs0, 9'd4);

    // stale valid held through ISSUE and first WAIT cycle
    stale_hold = 1'b1;
    load_batch({16'd12, 16'd8}, {16'd35, 16'd21}, {16'd9, 16'd6}, {16'd100, 16'd75});
    run0 = 1'b1;
    wait_done(1'b0, 500);
    check("c_sb_empty", sbq.size(), 0);
    check("c_pairs", pairs0, 9'd4);
    run0 = 1'b0;
    stale_hold = 1'b0;
    @(negedge clk);

    // watchdog timeout on pair 1
    hang_en = 1'b1; hang_val = 16'd7;
    load_batch({16'd30, 16'd12}, {16'd7, 16'd7}, {16'd81, 16'd27}, {16'd0, 16'd5});
    run0 = 1'b1;
    wait_done(1'b0, 1000);
    check("d_sb_empty", sbq.size(), 0);
    check("d_err", err0, 9'd1);
    check("d_pairs", pairs0, 9'd4);
    run0 = 1'b0;
    hang_en = 1'b0;
    @(negedge clk);

    // reset while waiting on pair 2
    load_batch({16'd12, 16'd8}, {16'd35, 16'd21}, {16'd9, 16'd6}, {16'd100, 16'd75});
    run0 = 1'b1;
    seen = 0;
    for (int k = 0; k < 200 && seen < 3; k++) begin
      @(negedge clk);
      if (start0) seen++;
    end
    check("e_third_issue", seen, 3);
    @(negedge clk);
    rst = 1'b1;
    run0 = 1'b0;
    @(negedge clk);
    check_all_zero("midwait_reset");
    sbq.delete();
    rst = 1'b0;
    @(negedge clk);
    load_batch({16'd12, 16'd8}, {16'd35, 16'd21}, {16'd9, 16'd6}, {16'd100, 16'd75});
    run0 = 1'b1;
    wait_done(1'b0, 500);
    check("e_sb_empty", sbq.size(), 0);
    check("e_pairs", pairs0, 9'd4);

    // run held high through DONE must not restart
    base = n_starts;
    repeat (10) @(negedge clk);
    check("f_still_done", done0, 1'b1);
    check("f_no_restart", n_starts, base);
    run0 = 1'b0;
    @(negedge clk);
    check("f_idle", done0, 1'b0);
    check("f_pairs_kept", pairs0, 9'd4);
    load_batch({16'd48, 16'd18}, {16'd17, 16'd5}, 32'd0, {16'd1000, 16'd250});
    run0 = 1'b1;
    @(negedge clk);
    check("f_counters_cleared", {pairs0, err0}, 18'd0);
    check("f_busy", busy0, 1'b1);
    wait_done(1'b0, 500);
    check("f_sb_empty", sbq.size(), 0);
    check("f_pairs", pairs0, 9'd4);
    run0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
